// File: rtl/midi_pkg.sv
// midi_pkg: constants and types shared by the MIDI receive path.
//   MIDI_BAUD / SYS_CLK_HZ : default line rate and system clock.
//   midi_rx_state_e        : receiver FSM states.
//   NOTE_ON / NOTE_OFF     : status-byte values, also used by the message parser.
package midi_pkg;

  localparam int unsigned MIDI_BAUD  = 31250;
  localparam int unsigned SYS_CLK_HZ = 25000000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } midi_rx_state_e;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;

endpackage

// File: rtl/midi_rx_sync.sv
// midi_rx_sync: multi-flop synchronizer for the asynchronous MIDI input pin.
// Every stage resets to 1 (line idle level) so leaving reset never looks like a start bit.
//   clk_i : system clock
//   rst_i : synchronous, active-high reset
//   d_i   : raw asynchronous input
//   q_o   : synchronized output (last stage)
module midi_rx_sync
  import midi_pkg::*;
#(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1, LSB-first serial receiver for the MIDI input (31250 baud, idle high).
// Produces a one-cycle byte_valid strobe with byte_value, or a one-cycle framing_error
// strobe when the stop bit samples low. A held-low line (break) never re-arms as a start.
//   clk           : system clock
//   reset         : synchronous, active-high reset
//   midi_in       : raw MIDI line (idle = 1)
//   byte_valid    : one-cycle strobe, byte_value valid in that cycle
//   byte_value    : last correctly framed byte, held until the next valid byte
//   framing_error : one-cycle strobe when the stop bit samples 0
//   busy          : high whenever the receiver is not idle
// Build option: define MIDI_UART_RX_MAJORITY_EN to take every start-confirm, data and stop
// sample as the majority of rx at counts 2, 1 and 0 (same latency as the single-sample build).
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ       = SYS_CLK_HZ,
  parameter int unsigned BAUD         = MIDI_BAUD,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_in,
  output logic       byte_valid,
  output logic [7:0] byte_value,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);

  if ((CLKS_PER_BIT < 8) || ((CLKS_PER_BIT % 2) != 0)) begin : gen_bad_clks_per_bit
    $error("midi_uart_rx: CLKS_PER_BIT must be an even integer of at least 8");
  end
  if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
    $error("midi_uart_rx: SYNC_STAGES must be at least 2");
  end

  logic rx;      // synchronized line
  logic rx_bit;  // value used at a sample point

  midi_rx_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (midi_in),
    .q_o  (rx)
  );

`ifdef MIDI_UART_RX_MAJORITY_EN
  // hist_q[0] is rx one cycle ago (count 1), hist_q[1] two cycles ago (count 2).
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx};
    end
  end

  assign rx_bit = (rx & hist_q[0]) | (rx & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_bit = rx;
`endif

  midi_rx_state_e  state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      byte_value    <= 8'h00;
    end else begin
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx) begin
            state_q <= START;
            cnt_q   <= HalfM1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!rx_bit) begin
              state_q   <= DATA;
              cnt_q     <= BitM1;
              bit_idx_q <= '0;
            end else begin
              // Line rose before mid start bit: glitch, not a frame.
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q   <= {rx_bit, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            cnt_q     <= BitM1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (rx_bit) begin
              byte_value <= shift_q;
              byte_valid <= 1'b1;
              state_q    <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state_q       <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BREAK: begin
          if (rx) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: directed bench for midi_uart_rx.
// The DUT runs at 100 clk/bit (CLK_HZ = 3125000) so the whole run stays short; HALF = 50 and
// the pin-to-byte_valid latency is HALF + 9*100 + 1 + 2 = 953 cycles.
// The model predicts each frame from its waveform: the receiver locks onto the falling edge
// SYNC_STAGES cycles after the pin, then samples the line at HALF + k*CLKS_PER_BIT.
module tb_midi_uart_rx;

  localparam int Cpb    = 100;
  localparam int Half   = Cpb / 2;
  localparam int Sync   = 2;
  localparam int RstLen = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       midi_in = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_value;
  logic       framing_error;
  logic       busy;

  midi_uart_rx #(
    .CLK_HZ     (3125000),
    .BAUD       (31250),
    .SYNC_STAGES(Sync)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .midi_in      (midi_in),
    .byte_valid   (byte_valid),
    .byte_value   (byte_value),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected activity of one frame: busy over [b0,b1], strobe of 'kind' at cycle 'strobe'.
  typedef struct {
    int         b0;
    int         b1;
    int         strobe;
    int         kind;  // 0 none, 1 byte_valid, 2 framing_error
    logic [7:0] value;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] obs_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_busy = 0;
  int         last_valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line level 'off' cycles after the start edge of a frame.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int p,
                                     input int low_after, input int off);
    int idx = off / p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return stop;
    if (!stop && off < 10 * p + low_after) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void predict(input logic [7:0] b, input logic stop, input int p,
                                  input int low_after, input int s);
    ev_t        e;
    logic [7:0] v;
    int         d = s + Sync;
    int         samp = Half + 9 * Cpb;
    int         rel = 10 * p + low_after;
    for (int k = 0; k < 8; k++) v[k] = frame_bit(b, stop, p, low_after, Half + (k + 1) * Cpb);
    e.b0     = d + 1;
    e.strobe = d + samp + 1;
    e.value  = v;
    if (frame_bit(b, stop, p, low_after, samp)) begin
      e.kind = 1;
      e.b1   = d + samp;
    end else begin
      e.kind = 2;
      e.b1   = (d + rel > e.strobe) ? d + rel : e.strobe;
    end
    evq.push_back(e);
  endfunction

  task automatic idle(input int n);
    midi_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // glitch: invert the pin for one cycle at every sample point of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int p,
                            input int low_after, input int rst_off, input bit glitch);
    int s = cyc;
    predict(b, stop, p, low_after, s);
    for (int off = 0; off < 10 * p + low_after; off++) begin
      if (rst_off >= 0 && off == rst_off) reset = 1'b1;
      if (rst_off >= 0 && off == rst_off + RstLen) reset = 1'b0;
      midi_in = frame_bit(b, stop, p, low_after, off) ^
                (glitch && off >= Half && ((off - Half) % Cpb) == 0 && (off - Half) / Cpb <= 9);
      @(negedge clk);
    end
    midi_in = 1'b1;
  endtask

  task automatic send_glitch(input int len);
    ev_t e;
    int  s = cyc;
    e.b0     = s + Sync + 1;
    e.b1     = s + Sync + Half;
    e.strobe = -1;
    e.kind   = 0;
    e.value  = 8'h00;
    evq.push_back(e);
    midi_in = 1'b0;
    repeat (len) @(negedge clk);
    midi_in = 1'b1;
  endtask

  // Per-cycle compare against the model.
  initial begin : compare
    logic [7:0] exp_val;
    logic       exp_bv, exp_fe, exp_busy;
    exp_val = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      exp_bv   = 1'b0;
      exp_fe   = 1'b0;
      exp_busy = 1'b0;
      if (reset) begin
        evq.delete();
        exp_val = 8'h00;
      end else begin
        foreach (evq[i]) begin
          if (cyc >= evq[i].b0 && cyc <= evq[i].b1) exp_busy = 1'b1;
          if (cyc == evq[i].strobe) begin
            if (evq[i].kind == 1) begin
              exp_bv  = 1'b1;
              exp_val = evq[i].value;
            end else if (evq[i].kind == 2) begin
              exp_fe = 1'b1;
            end
          end
        end
        while (evq.size() > 0 && cyc >= evq[0].b1 && cyc >= evq[0].strobe) begin
          void'(evq.pop_front());
        end
      end
      chk("byte_valid", {31'd0, byte_valid}, {31'd0, exp_bv});
      chk("framing_error", {31'd0, framing_error}, {31'd0, exp_fe});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("byte_value", {24'd0, byte_value}, {24'd0, exp_val});
      if (byte_valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        obs_q.push_back(byte_value);
      end
      if (framing_error === 1'b1) n_ferr++;
      if (busy === 1'b1) n_busy++;
    end
  end

  initial begin : stimulus
    int         s0, n0, f0, b0;
    int         periods[3];
    logic [7:0] seq[3];
    periods = '{100, 98, 102};
    seq     = '{8'h90, 8'h3C, 8'h64};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle line after reset.
    idle(10000);
    chk("idle_valid_count", n_valid, 0);
    chk("idle_ferr_count", n_ferr, 0);
    chk("idle_busy_cycles", n_busy, 0);
    chk("idle_value", {24'd0, byte_value}, 32'h00);

    // Single frame, exact rate.
    s0 = cyc;
    send_frame(8'h90, 1'b1, Cpb, 0, -1, 1'b0);
    idle(200);
    chk("single_count", n_valid, 1);
    chk("single_latency", last_valid_cyc - s0, 953);
    chk("single_value", {24'd0, obs_q.pop_front()}, 32'h90);

    // Back-to-back frames at nominal and +/-2% bit period.
    foreach (periods[j]) begin
      n0 = n_valid;
      foreach (seq[i]) send_frame(seq[i], 1'b1, periods[j], 0, -1, 1'b0);
      idle(200);
      chk("b2b_count", n_valid - n0, 3);
      chk("b2b_first", {24'd0, obs_q.pop_front()}, 32'h90);
      chk("b2b_second", {24'd0, obs_q.pop_front()}, 32'h3C);
      chk("b2b_third", {24'd0, obs_q.pop_front()}, 32'h64);
    end

    // Bad stop bit followed by a 3-bit break, then a clean frame.
    n0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h45, 1'b0, Cpb, 3 * Cpb, -1, 1'b0);
    chk("break_ferr_count", n_ferr - f0, 1);
    chk("break_no_valid", n_valid - n0, 0);
    chk("break_busy_held", {31'd0, busy}, 32'd1);
    chk("break_value_kept", {24'd0, byte_value}, 32'h64);
    idle(Cpb);
    send_frame(8'h80, 1'b1, Cpb, 0, -1, 1'b0);
    idle(200);
    chk("after_break_count", n_valid - n0, 1);
    chk("after_break_value", {24'd0, obs_q.pop_front()}, 32'h80);

    // Short low glitch on an idle line.
    n0 = n_valid;
    f0 = n_ferr;
    b0 = n_busy;
    send_glitch(Cpb / 4);
    idle(200);
    chk("glitch_busy_cycles", n_busy - b0, Half);
    chk("glitch_no_valid", n_valid - n0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);

    // Reset during data bit 4 of 8'hFF, then a clean frame.
    n0 = n_valid;
    f0 = n_ferr;
    send_frame(8'hFF, 1'b1, Cpb, 0, 5 * Cpb + 10, 1'b0);
    idle(200);
    chk("abort_no_valid", n_valid - n0, 0);
    chk("abort_no_ferr", n_ferr - f0, 0);
    chk("abort_value_reset", {24'd0, byte_value}, 32'h00);
    send_frame(8'hF8, 1'b1, Cpb, 0, -1, 1'b0);
    idle(200);
    chk("post_reset_count", n_valid - n0, 1);
    chk("post_reset_value", {24'd0, obs_q.pop_front()}, 32'hF8);

`ifdef MIDI_UART_RX_MAJORITY_EN
    // One-cycle inverted pulse at every sample point must be voted out.
    n0 = n_valid;
    send_frame(8'hA5, 1'b1, Cpb, 0, -1, 1'b1);
    idle(200);
    chk("majority_count", n_valid - n0, 1);
    chk("majority_value", {24'd0, obs_q.pop_front()}, 32'hA5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
